// File: rtl/vm_display_pkg.sv
// Shared definitions for the vending-machine display path: mode codes,
// digit codes and the conversion FSM encoding used by encoder and decoder.
package vm_display_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_MONEY  = 2'b01,
        MODE_CHANGE = 2'b10,
        MODE_ALERT  = 2'b11
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } conv_state_t;

    localparam logic [3:0] CODE_BLANK  = 4'b1111;
    localparam logic [3:0] CODE_EIGHT  = 4'b1000;
    localparam logic [3:0] CODE_ALERT  = 4'b1010;
    localparam logic [6:0] MAX_DISPLAY = 7'd99;

    function automatic logic [6:0] sat_display(input logic [6:0] value);
        return (value > MAX_DISPLAY) ? MAX_DISPLAY : value;
    endfunction

    // A leading zero in the tens place is never shown; the decoder renders
    // CODE_BLANK as empty in money mode and as '-' in change mode.
    function automatic logic [3:0] tens_code(input logic [3:0] tens);
        return (tens == 4'd0) ? CODE_BLANK : tens;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative subtract-10 binary-to-BCD converter for values 0..99 (inputs
// above 99 saturate). Takes tens+1 cycles per conversion.
module bin2bcd_seq
    import vm_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [6:0]  i_value,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_tens,
    output logic [3:0]  o_units,
    output conv_state_t o_state
);

    // Handshake: i_start is accepted on an edge only while o_busy is low.
    // o_busy is high from that edge until the edge on which o_done is high;
    // o_done is a combinational one-cycle strobe, and o_tens/o_units are
    // final and stable whenever o_done is high.
    conv_state_t r_state;
    conv_state_t w_state_nxt;
    logic [6:0]  r_rem;
    logic [6:0]  w_rem_nxt;
    logic [3:0]  r_tens;
    logic [3:0]  w_tens_nxt;
    logic        w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= 7'd0;
            r_tens <= 4'd0;
        end else begin
            r_rem  <= w_rem_nxt;
            r_tens <= w_tens_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_tens_nxt  = r_tens;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_rem_nxt   = sat_display(i_value);
                    w_tens_nxt  = 4'd0;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (r_rem >= 7'd10) begin
                    w_rem_nxt  = r_rem - 7'd10;
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_busy  = (r_state == S_CONV);
    assign o_done  = w_done;
    assign o_tens  = r_tens;
    assign o_units = r_rem[3:0];
    assign o_state = r_state;

endmodule

// File: rtl/display_encoder.sv
// Converts a money/change amount into tens/units display codes, plus the
// change-mode flag, alert pattern and a blinking '8' for the idle display.
module display_encoder
    import vm_display_pkg::*;
#(
    parameter int BLINK_DIV = 25000000,
    parameter int CNT_W     = $clog2(BLINK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] mode_in,
    input  logic [6:0] value_in,
    output logic [3:0] Eout1,
    output logic [3:0] Eout2,
    output logic       state_o,
    output logic       busy,
    output logic       valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    mode_t             r_pend_mode;
    mode_t             r_disp_mode;
    logic [3:0]        r_eout1;
    logic [3:0]        r_eout2;
    logic              r_state_o;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_phase;

    mode_t             w_mode_in;
    logic              w_start;
    logic [6:0]        w_conv_value;
    logic              w_conv_busy;
    logic              w_conv_done;
    logic [3:0]        w_conv_tens;
    logic [3:0]        w_conv_units;
    conv_state_t       w_conv_state;

    assign w_mode_in = mode_t'(mode_in);
    assign w_start   = load && (w_conv_state == S_IDLE);
    // Idle and alert displays carry no number, so convert zero for them.
    assign w_conv_value = ((w_mode_in == MODE_IDLE) || (w_mode_in == MODE_ALERT))
                          ? 7'd0 : value_in;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_value (w_conv_value),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_tens  (w_conv_tens),
        .o_units (w_conv_units),
        .o_state (w_conv_state)
    );

    // The requested mode is held aside until the conversion finishes so the
    // visible display never changes mid-conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_mode <= MODE_IDLE;
        end else if (w_start) begin
            r_pend_mode <= w_mode_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_mode <= MODE_IDLE;
            r_eout1     <= CODE_BLANK;
            r_eout2     <= CODE_BLANK;
            r_state_o   <= 1'b0;
            r_valid     <= 1'b0;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_valid <= w_conv_done;
            if (w_conv_done) begin
                r_disp_mode <= r_pend_mode;
                r_cnt       <= '0;
                r_phase     <= 1'b0;
                r_state_o   <= (r_pend_mode == MODE_CHANGE);
                case (r_pend_mode)
                    MODE_MONEY, MODE_CHANGE: begin
                        r_eout1 <= tens_code(w_conv_tens);
                        r_eout2 <= w_conv_units;
                    end
                    MODE_ALERT: begin
                        r_eout1 <= CODE_ALERT;
                        r_eout2 <= CODE_ALERT;
                    end
                    default: begin
                        r_eout1 <= CODE_BLANK;
                        r_eout2 <= CODE_BLANK;
                    end
                endcase
            end else if (r_disp_mode == MODE_IDLE) begin
                // Outputs are loaded together with the phase toggle so the
                // visible blink lines up with the wrap edge.
                if (r_cnt == CNT_MAX) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                    r_eout1 <= r_phase ? CODE_BLANK : CODE_EIGHT;
                    r_eout2 <= r_phase ? CODE_BLANK : CODE_EIGHT;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign Eout1   = r_eout1;
    assign Eout2   = r_eout2;
    assign state_o = r_state_o;
    assign busy    = w_conv_busy;
    assign valid   = r_valid;

endmodule

// File: tb/tb_display_encoder.sv
// Directed bench for display_encoder with a short blink period.
module tb_display_encoder;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [1:0] mode_in;
    logic [6:0] value_in;
    logic [3:0] Eout1;
    logic [3:0] Eout2;
    logic       state_o;
    logic       busy;
    logic       valid;

    int n_vec;
    int n_err;

    logic [3:0] cur1;
    logic [3:0] cur2;
    logic       cur_st;

    display_encoder #(.BLINK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .mode_in  (mode_in),
        .value_in (value_in),
        .Eout1    (Eout1),
        .Eout2    (Eout2),
        .state_o  (state_o),
        .busy     (busy),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                             input logic est);
        check({tag, "_e1"}, {28'd0, Eout1}, {28'd0, e1});
        check({tag, "_e2"}, {28'd0, Eout2}, {28'd0, e2});
        check({tag, "_st"}, {31'd0, state_o}, {31'd0, est});
    endtask

    // Loads one request and waits (bounded) for the valid pulse.
    task automatic run_conv(input string tag, input logic [1:0] m, input logic [6:0] v,
                            input int lat, input logic [3:0] e1, input logic [3:0] e2,
                            input logic est);
        int n;
        int busy_n;
        load     = 1'b1;
        mode_in  = m;
        value_in = v;
        tick();
        load   = 1'b0;
        n      = 0;
        busy_n = 0;
        while (valid !== 1'b1 && n < 15) begin
            if (busy === 1'b1) busy_n++;
            check_out({tag, "_hold"}, cur1, cur2, cur_st);
            tick();
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy_cycles"}, busy_n, lat);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        check_out(tag, e1, e2, est);
        tick();
        check({tag, "_valid_1cyc"}, {31'd0, valid}, 32'd0);
        cur1   = e1;
        cur2   = e2;
        cur_st = est;
    endtask

    initial begin
        int n;
        logic [3:0] exp_c;
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        mode_in  = 2'b00;
        value_in = 7'd0;

        // Reset and idle blinking: '8' from edge 4, blank again at edge 8.
        #22;
        rst_n = 1'b1;
        #1;
        check_out("reset", 4'b1111, 4'b1111, 1'b0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_c = (e >= 4 && e < 8) ? 4'b1000 : 4'b1111;
            check_out($sformatf("blink%0d", e), exp_c, exp_c, 1'b0);
        end
        cur1   = 4'b1111;
        cur2   = 4'b1111;
        cur_st = 1'b0;

        run_conv("change7", 2'b10, 7'd7, 1, 4'b1111, 4'b0111, 1'b1);
        run_conv("money0", 2'b01, 7'd0, 1, 4'b1111, 4'b0000, 1'b0);
        run_conv("money57", 2'b01, 7'd57, 6, 4'b0101, 4'b0111, 1'b0);
        run_conv("money120", 2'b01, 7'd120, 10, 4'b1001, 4'b1001, 1'b0);

        // Second load while busy is dropped.
        load = 1'b1; mode_in = 2'b01; value_in = 7'd85;
        tick();
        load = 1'b0;
        tick();
        load = 1'b1; mode_in = 2'b10; value_in = 7'd3;
        tick();
        load = 1'b0;
        n = 2;
        while (valid !== 1'b1 && n < 15) begin
            tick();
            n++;
        end
        check("drop_lat", n, 9);
        check_out("drop", 4'b1000, 4'b0101, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drop_noqueue_valid", {31'd0, valid}, 32'd0);
            check("drop_noqueue_busy", {31'd0, busy}, 32'd0);
        end
        check_out("drop_after", 4'b1000, 4'b0101, 1'b0);

        // Reset in the middle of a conversion.
        load = 1'b1; mode_in = 2'b01; value_in = 7'd85;
        tick();
        load = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_out("midrst", 4'b1111, 4'b1111, 1'b0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        tick();
        check("midrst_hold_valid", {31'd0, valid}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check("midrst_rel_valid", {31'd0, valid}, 32'd0);
        check_out("midrst_rel", 4'b1111, 4'b1111, 1'b0);
        cur1   = 4'b1111;
        cur2   = 4'b1111;
        cur_st = 1'b0;

        // Alert is static: no blinking afterwards.
        run_conv("alert42", 2'b11, 7'd42, 1, 4'b1010, 4'b1010, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check(	"alert_static_e1", {28'd0, Eout1}, 32'h0000000a);
            check("alert_static_e2", {28'd0, Eout2}, 32'h0000000a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_encoder.md
Name: display_encoder

Overview:
- Producer side of the 7-segment digit-code interface. Converts the vending machine's money-sum or change amount into two 4-bit display codes: tens on Eout1, units on Eout2.
- Also drives the state flag that tells the downstream 7-segment decoder to render code 4'b1111 as a dash in change mode.
- Uses a small iterative binary-to-BCD converter and a breathing-'8' blink generator for the idle display.

Parameters:
- BLINK_DIV, 25000000, clock cycles per blink half-period in IDLE display (0.5 s at 50 MHz); must be at least 2.
- CNT_W, $clog2(BLINK_DIV), blink counter width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle request to latch mode_in/value_in; honoured only when busy=0.
- mode_in  input  2  00=IDLE, 01=MONEY, 10=CHANGE, 11=ALERT.
- value_in  input  7  binary amount, 0..127.
- Eout1  output  4  tens-digit code to the decoder.
- Eout2  output  4  units-digit code to the decoder.
- state_o  output  1  1 while the displayed mode is CHANGE, else 0.
- busy  output  1  conversion in progress; load is ignored while high.
- valid  output  1  one-cycle pulse when new display outputs take effect.

Behaviour:
- Reset is asynchronous, active-low, and takes effect mid-operation (aborts any conversion). Reset values:
  - Eout1 = Eout2 = 4'b1111, state_o = 0, busy = 0, valid = 0.
  - Displayed mode = IDLE, blink counter = 0, blink phase = 0.
- FSM has two states, S_IDLE and S_CONV.
- S_IDLE: on load=1 at edge k:
  - Latch mode_in.
  - Latch rem = min(value_in, 99), so values above 99 saturate to 99.
  - Clear tens to 0, set busy=1, go to S_CONV.
  - For IDLE or ALERT mode, rem is forced to 0.
- S_CONV, each edge:
  - If rem >= 10: rem -= 10 and tens += 1.
  - Otherwise: write the display outputs, pulse valid=1 for one cycle, set busy=0, return to S_IDLE.
- Latency: outputs and valid change at edge k+T+1, where T is the tens digit. Value 0 takes 1 cycle; value 99 takes 10 cycles. busy is high for T+1 cycles.
- load while busy=1 is dropped; no queueing.
- Output formatting, applied at the valid edge:
  - MONEY: Eout1 = tens, or 4'b1111 (blank) if tens = 0; Eout2 = units; state_o = 0.
  - CHANGE: Eout1 = tens, or 4'b1111 if tens = 0, which the decoder shows as '-'; Eout2 = units; state_o = 1.
  - ALERT: Eout1 = Eout2 = 4'b1010; state_o = 0; static.
  - IDLE: state_o = 0; at the valid edge both outputs are 4'b1111 (phase 0).
- IDLE display blinking:
  - The blink counter and phase are cleared at every valid edge.
  - While the displayed mode is IDLE, the counter increments each cycle. At BLINK_DIV-1 it wraps to 0 and the phase toggles.
  - Phase 1 gives Eout1 = Eout2 = 4'b1000 (breathing '8'); phase 0 gives both 4'b1111.
  - The counter is frozen in other modes.
- Previous outputs hold throughout a conversion; no intermediate values are visible.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package vm_display_pkg holds:
  - Mode codes MODE_IDLE, MODE_MONEY, MODE_CHANGE, MODE_ALERT.
  - Digit codes CODE_BLANK = 4'b1111, CODE_EIGHT = 4'b1000, CODE_ALERT = 4'b1010.
  - MAX_DISPLAY = 99.
- The decoder imports the same package.
- One sub-module: bin2bcd_seq.
  - Iterative subtract-10 converter with start/busy/done handshake and tens/units outputs.
  - It is reused later for price display.
- The blink logic and output formatting stay in display_encoder.

Test Plan:
1. Reset with BLINK_DIV=4 and no load → Eout1/Eout2 = 1111/1111; 1000/1000 from the 4th edge; back to 1111/1111 at the 8th edge; state_o = 0 throughout.
2. load MONEY, value 57, at edge k → busy high for 6 cycles; valid pulse at edge k+6; Eout1 = 0101, Eout2 = 0111, state_o = 0; outputs unchanged before k+6.
3. load CHANGE, value 7 → valid at k+1; Eout1 = 1111, Eout2 = 0111, state_o = 1. Then load MONEY, value 0 → 1111/0000, state_o = 0.
4. load MONEY, value 120 → saturates; valid at k+10; Eout1 = 1001, Eout2 = 1001.
5. load MONEY 85, then a second load (CHANGE 3) two cycles later while busy → second load ignored; final outputs 1000/0101 with state_o = 0. Repeat, asserting rst_n low at k+3 → outputs go to reset values immediately with no valid pulse.
6. load ALERT, value 42 → valid at k+1; Eout1 = Eout2 = 1010 held static for 20 cycles (no blinking).
